// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave frame engine.
// Holds the FSM state encoding and the two-bit command codes.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int TMO_W = 16;

    // Only read-data frames hand miso over to the RAM read path.
    function automatic logic needs_tx(input logic [1:0] cmd);
        return cmd == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// SPI pins plus RAM-side frame/handshake signals of the slave frame engine.
// The slave modport is the engine's view, the master modport the environment's.
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W+1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              frame_abort;
    logic              tx_timeout;
    logic              busy;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid, frame_abort, tx_timeout, busy
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid, frame_abort, tx_timeout, busy
    );
endinterface

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser driving the registered miso line.
// done_o rises once all DATA_W bits have been presented on miso.
module spi_tx_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              miso_o,
    output logic              done_o
);
    localparam int CNT_W = $clog2(DATA_W + 2);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miso_q, miso_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        if (clear_i) begin
            miso_d = 1'b0;
            cnt_d  = '0;
        end else if (load_i) begin
            miso_d  = data_i[DATA_W-1];
            shift_d = data_i << 1;
            cnt_d   = CNT_W'(1);
        end else if (shift_i) begin
            miso_d  = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            miso_q <= miso_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload bits need no reset: they only reach miso after a load.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign miso_o = miso_q;
    assign done_o = (cnt_q == CNT_W'(DATA_W));

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave frame engine: deserialises cmd+payload frames, serves read data on
// miso, supports back-to-back burst frames and reports aborts and TX timeouts.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16,
    parameter int BURST      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_slave_param_if.slave      spi_if
);
    localparam int               FRAME_W  = DATA_W + 2;
    localparam int               CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);
    localparam bit               BURST_EN = (BURST != 0);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W:0]      rx_shift_q, rx_shift_d;
    logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 abort_q, abort_d;
    logic                 timeout_q, timeout_d;
    logic                 rx_shift_en;
    logic                 tx_load, tx_shift, tx_clear, tx_done;
    logic                 miso;
    logic                 frame_last;
    logic [1:0]           cmd_rx;

    assign frame_last = (bit_cnt_q == LAST_BIT);
    // Bit 0 of the frame sits at the top of the shifter once DATA_W+1 bits are in.
    assign cmd_rx     = rx_shift_q[DATA_W -: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!spi_if.ss_n) state_d = ST_RX;
            end
            ST_RX: begin
                if (spi_if.ss_n) begin
                    state_d = ST_IDLE;
                end else if (frame_last) begin
                    if (needs_tx(cmd_rx)) state_d = ST_WAIT_TX;
                    else                  state_d = BURST_EN ? ST_RX : ST_DONE;
                end
            end
            ST_WAIT_TX: begin
                if (spi_if.ss_n)                 state_d = ST_IDLE;
                else if (spi_if.tx_valid)        state_d = ST_TX;
                else if (tmo_cnt_q == TMO_LAST)  state_d = ST_DONE;
            end
            ST_TX: begin
                if (spi_if.ss_n)  state_d = ST_IDLE;
                else if (tx_done) state_d = BURST_EN ? ST_RX : ST_DONE;
            end
            ST_DONE: begin
                if (spi_if.ss_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        abort_d     = 1'b0;
        timeout_d   = 1'b0;
        rx_shift_en = 1'b0;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        tx_clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!spi_if.ss_n) begin
                    rx_shift_en = 1'b1;
                    bit_cnt_d   = CNT_W'(1);
                end
            end
            ST_RX: begin
                if (spi_if.ss_n) begin
                    // bit_cnt 0 is a burst boundary, not a broken frame.
                    abort_d   = (bit_cnt_q != '0);
                    bit_cnt_d = '0;
                end else begin
                    rx_shift_en = 1'b1;
                    if (frame_last) begin
                        rx_data_d  = {rx_shift_q, spi_if.mosi};
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tmo_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_TX: begin
                if (spi_if.ss_n) begin
                    abort_d  = 1'b1;
                    tx_clear = 1'b1;
                end else if (spi_if.tx_valid) begin
                    tx_load = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_TX: begin
                if (spi_if.ss_n) begin
                    abort_d  = 1'b1;
                    tx_clear = 1'b1;
                end else if (tx_done) begin
                    tx_clear  = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    tx_shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            abort_q    <= abort_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rx_shift_d = rx_shift_en ? {rx_shift_q[DATA_W-1:0], spi_if.mosi} : rx_shift_q;

    // A full frame always shifts in fresh bits, so stale contents never leak.
    always_ff @(posedge clk) begin
        rx_shift_q <= rx_shift_d;
    end

    spi_tx_shifter #(
        .DATA_W (DATA_W)
    ) u_tx_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tx_load),
        .shift_i (tx_shift),
        .clear_i (tx_clear),
        .data_i  (spi_if.tx_data),
        .miso_o  (miso),
        .done_o  (tx_done)
    );

    assign spi_if.miso        = miso;
    assign spi_if.rx_data     = rx_data_q;
    assign spi_if.rx_valid    = rx_valid_q;
    assign spi_if.frame_abort = abort_q;
    assign spi_if.tx_timeout  = timeout_q;
    assign spi_if.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: a burst and a non-burst instance share
// one stimulus stream; received frames are checked against per-instance queues.
module tb_spi_slave_param;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          ss_n;
    logic          mosi;
    logic          tx_valid;
    logic [DW-1:0] tx_data;

    int checks   = 0;
    int failures = 0;

    logic [DW+1:0] q1[$];
    logic [DW+1:0] q0[$];

    spi_slave_param_if #(.DATA_W(DW)) bus1 ();
    spi_slave_param_if #(.DATA_W(DW)) bus0 ();

    assign bus1.ss_n     = ss_n;
    assign bus1.mosi     = mosi;
    assign bus1.tx_valid = tx_valid;
    assign bus1.tx_data  = tx_data;
    assign bus0.ss_n     = ss_n;
    assign bus0.mosi     = mosi;
    assign bus0.tx_valid = tx_valid;
    assign bus0.tx_data  = tx_data;

    spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(16), .BURST(1)) u_dut_b1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .spi_if (bus1)
    );

    spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(16), .BURST(0)) u_dut_b0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .spi_if (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the first n bits of frame f (MSB first) with ss_n low.
    task automatic send_bits(input logic [DW+1:0] f, input int n);
        for (int j = 0; j < n; j++) begin
            ss_n = 1'b0;
            mosi = f[DW+1-j];
            tick();
            if (j < DW + 1) begin
                check("rx_valid_mid_frame_b1", {31'd0, bus1.rx_valid}, 32'd0);
                check("rx_valid_mid_frame_b0", {31'd0, bus0.rx_valid}, 32'd0);
                check("miso_during_rx", {31'd0, bus1.miso}, 32'd0);
            end
        end
    endtask

    // Scoreboard side: every rx_valid strobe consumes one expected frame.
    always @(negedge clk) begin
        if (rst_n && bus1.rx_valid) begin
            check("sb_b1_frame_expected", {31'd0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) check("sb_b1_rx_data", bus1.rx_data, q1.pop_front());
        end
        if (rst_n && bus0.rx_valid) begin
            check("sb_b0_frame_expected", {31'd0, q0.size() != 0}, 32'd1);
            if (q0.size() != 0) check("sb_b0_rx_data", bus0.rx_data, q0.pop_front());
        end
    end

    initial begin
        logic [DW-1:0] rd_val;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) tick();

        // Reset values
        check("rst_miso", {31'd0, bus1.miso}, 32'd0);
        check("rst_rx_data", bus1.rx_data, 32'd0);
        check("rst_rx_valid", {31'd0, bus1.rx_valid}, 32'd0);
        check("rst_abort", {31'd0, bus1.frame_abort}, 32'd0);
        check("rst_timeout", {31'd0, bus1.tx_timeout}, 32'd0);
        check("rst_busy", {31'd0, bus1.busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // tx_valid while idle must not start anything
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        tick();
        check("idle_txv_miso", {31'd0, bus1.miso}, 32'd0);
        check("idle_txv_busy", {31'd0, bus1.busy}, 32'd0);

        // Write-address frame
        q1.push_back(10'h0A5);
        q0.push_back(10'h0A5);
        send_bits(10'h0A5, 10);
        check("wr_rx_valid", {31'd0, bus1.rx_valid}, 32'd1);
        check("wr_rx_data", bus1.rx_data, 32'h0A5);
        check("wr_miso", {31'd0, bus1.miso}, 32'd0);
        ss_n = 1'b1;
        tick();
        check("wr_rx_valid_single", {31'd0, bus1.rx_valid}, 32'd0);
        check("wr_end_no_abort_b1", {31'd0, bus1.frame_abort}, 32'd0);
        check("wr_end_no_abort_b0", {31'd0, bus0.frame_abort}, 32'd0);
        check("wr_end_idle", {31'd0, bus1.busy}, 32'd0);

        // Read-data frame, tx_valid three cycles after the last bit
        q1.push_back(10'h300);
        q0.push_back(10'h300);
        send_bits(10'h300, 10);
        mosi = 1'b0;
        repeat (2) begin
            tick();
            check("rd_wait_miso", {31'd0, bus1.miso}, 32'd0);
        end
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        rd_val   = 8'hC3;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int b = DW - 1; b >= 0; b--) begin
            check("rd_miso_bit_b1", {31'd0, bus1.miso}, {31'd0, rd_val[b]});
            check("rd_miso_bit_b0", {31'd0, bus0.miso}, {31'd0, rd_val[b]});
            tick();
        end
        check("rd_miso_after", {31'd0, bus1.miso}, 32'd0);
        check("rd_busy_after", {31'd0, bus1.busy}, 32'd1);
        ss_n = 1'b1;
        tick();
        check("rd_end_no_abort_b1", {31'd0, bus1.frame_abort}, 32'd0);
        check("rd_end_no_abort_b0", {31'd0, bus0.frame_abort}, 32'd0);
        check("rd_end_idle", {31'd0, bus0.busy}, 32'd0);

        // Abort after five bits
        send_bits(10'h1FF, 5);
        ss_n = 1'b1;
        tick();
        check("abort_pulse_b1", {31'd0, bus1.frame_abort}, 32'd1);
        check("abort_pulse_b0", {31'd0, bus0.frame_abort}, 32'd1);
        check("abort_no_rx_valid", {31'd0, bus1.rx_valid}, 32'd0);
        check("abort_rx_data_kept", bus1.rx_data, 32'h300);
        check("abort_idle", {31'd0, bus1.busy}, 32'd0);
        tick();
        check("abort_one_cycle", {31'd0, bus1.frame_abort}, 32'd0);

        // Read-data frame with no tx_valid: timeout on the 16th WAIT_TX edge
        q1.push_back(10'h355);
        q0.push_back(10'h355);
        send_bits(10'h355, 10);
        mosi = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                check("tmo_not_yet", {31'd0, bus1.tx_timeout}, 32'd0);
            end
        end
        check("tmo_pulse_b1", {31'd0, bus1.tx_timeout}, 32'd1);
        check("tmo_pulse_b0", {31'd0, bus0.tx_timeout}, 32'd1);
        check("tmo_miso", {31'd0, bus1.miso}, 32'd0);
        tick();
        check("tmo_one_cycle", {31'd0, bus1.tx_timeout}, 32'd0);
        check("tmo_done_busy", {31'd0, bus1.busy}, 32'd1);
        ss_n = 1'b1;
        tick();
        check("tmo_end_no_abort", {31'd0, bus1.frame_abort}, 32'd0);
        check("tmo_end_idle", {31'd0, bus1.busy}, 32'd0);

        // Back-to-back frames with ss_n held low
        q1.push_back(10'h0A5);
        q1.push_back(10'h1FF);
        q0.push_back(10'h0A5);
        send_bits(10'h0A5, 10);
        check("burst_first_b1", {31'd0, bus1.rx_valid}, 32'd1);
        check("burst_first_b0", {31'd0, bus0.rx_valid}, 32'd1);
        send_bits(10'h1FF, 10);
        check("burst_second_b1", {31'd0, bus1.rx_valid}, 32'd1);
        check("burst_second_data_b1", bus1.rx_data, 32'h1FF);
        check("burst_second_b0", {31'd0, bus0.rx_valid}, 32'd0);
        check("burst_second_data_b0", bus0.rx_data, 32'h0A5);
        ss_n = 1'b1;
        tick();
        check("burst_end_no_abort_b1", {31'd0, bus1.frame_abort}, 32'd0);
        check("burst_end_no_abort_b0", {31'd0, bus0.frame_abort}, 32'd0);

        // Reset asserted while TX is presenting bit 3
        q1.push_back(10'h300);
        q0.push_back(10'h300);
        send_bits(10'h300, 10);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        tick();
        tx_valid = 1'b0;
        repeat (4) tick();
        check("pre_rst_bit3", {31'd0, bus1.miso}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", {31'd0, bus1.miso}, 32'd0);
        check("mid_rst_busy", {31'd0, bus1.busy}, 32'd0);
        check("mid_rst_rx_data", bus1.rx_data, 32'd0);
        check("mid_rst_abort", {31'd0, bus1.frame_abort}, 32'd0);
        ss_n = 1'b1;
        tick();
        check("mid_rst_no_abort", {31'd0, bus1.frame_abort}, 32'd0);
        rst_n = 1'b1;
        tick();
        q1.push_back(10'h1FF);
        q0.push_back(10'h1FF);
        send_bits(10'h1FF, 10);
        check("post_rst_rx_valid", {31'd0, bus1.rx_valid}, 32'd1);
        check("post_rst_rx_data", bus1.rx_data, 32'h1FF);
        ss_n = 1'b1;
        repeat (2) tick();

        check("sb_b1_drained", q1.size(), 32'd0);
        check("sb_b0_drained", q0.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave frame engine between an SPI master (ss_n/mosi/miso, sampled on the system clock) and a single-port RAM controller. It deserialises command+data frames of DATA_W+2 bits, presents them to the RAM side with a one-cycle valid strobe, and serialises RAM read data back on miso. It adds three behaviours the first-generation slave lacked: configurable width, back-to-back burst frames, and explicit abort and timeout reporting.

## Interface
- DATA_W, 8: RAM data/address payload width; frame length is DATA_W+2 bits.
- TX_TIMEOUT, 16: max cycles waiting in WAIT_TX for tx_valid; range 1..2^16-1.
- BURST, 1: 1 = a new frame starts immediately if ss_n stays low after a frame; 0 = slave idles in DONE until ss_n rises.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ss_n  in  1  slave select, active-low; pre-synchronised by instantiator.
- mosi  in  1  serial data in, MSB first; pre-synchronised.
- miso  out  1  serial data out, MSB first; registered.
- rx_data  out  DATA_W+2  last complete frame; [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid; sampled only in WAIT_TX.
- frame_abort  out  1  one-cycle pulse: ss_n rose mid-frame.
- tx_timeout  out  1  one-cycle pulse: WAIT_TX expired.
- busy  out  1  state != IDLE (combinational from state register).

## Operation
- Cmd encodings: 00 write addr, 01 write data, 10 read addr, 11 read data.
- States: IDLE, RX, WAIT_TX, TX, DONE.
- IDLE: ss_n low at an edge -> RX, bit 0 sampled on that same edge, bit_cnt <= 1.
- RX: each edge shifts mosi into rx_shift; on the edge sampling bit DATA_W+1, rx_data <= {rx_shift, mosi} and rx_valid <= 1. Next state: cmd 11 -> WAIT_TX (tmo_cnt <= 0); else BURST ? RX (bit_cnt <= 0) : DONE.
- WAIT_TX: tx_valid high -> tx_shift <= tx_data, miso <= tx_data[DATA_W-1], -> TX with tx_cnt <= 1. Else tmo_cnt increments; at tmo_cnt == TX_TIMEOUT-1 -> tx_timeout pulse, DONE, miso stays 0.
- TX: each edge miso <= next lower bit; after bit 0 has been held one cycle, miso <= 0, -> BURST ? RX : DONE.
- DONE: ss_n high -> IDLE; mosi ignored.
- ss_n high at any edge in RX with bit_cnt > 0, WAIT_TX or TX: -> IDLE, frame_abort pulse, no rx_valid, miso <= 0, partial shift discarded. ss_n high in RX with bit_cnt == 0 (burst boundary) or in DONE: -> IDLE, no pulse.
- tx_valid outside WAIT_TX ignored; tx_valid on the same edge as a timeout wins (data accepted, no timeout).
- Counters are $clog2(DATA_W+2) and 16 bits wide; no wrap-around reachable.

## Timing
- Reset values: miso 0, rx_data 0, rx_valid 0, frame_abort 0, tx_timeout 0, state IDLE, busy 0.
- rx_valid high exactly the cycle after the last-bit sample edge; rx_data holds until the next complete frame.
- Read latency: miso shows the MSB the cycle after the edge tx_valid is sampled; each bit held exactly 1 cycle; DATA_W cycles total.
- rx_valid never asserted twice in consecutive cycles (minimum frame length 3).
- rst_n asserted mid-frame: immediate return to reset values, no abort pulse.

## Structure
- spi_slave_pkg: state enum, CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA constants.
- One sub-module: spi_tx_shifter (load, shift, miso register, done flag), parametrised by DATA_W.
- RAM is not instantiated inside; the integrator connects it at the top level.

## Test plan
- DATA_W=8, write frame 00_1010_0101 -> rx_data 0x0A5, rx_valid high one cycle after the 10th sample, miso 0 throughout.
- Read frame 11_0000_0000, tx_valid+tx_data 0xC3 three cycles later -> miso 1,1,0,0,0,0,1,1 starting the next cycle, then 0.
- ss_n rises after 5 bits -> frame_abort one cycle, no rx_valid, rx_data unchanged, IDLE.
- TX_TIMEOUT=16, read-data frame with no tx_valid -> tx_timeout on the 16th WAIT_TX cycle, DONE, miso 0.
- BURST=1, frames 0x0A5 then 0x1FF back-to-back with ss_n low -> two rx_valid pulses 10 cycles apart; BURST=0 -> second frame ignored.
- rst_n low during TX bit 3 -> all outputs at reset values immediately, next frame decoded correctly.
